// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button inputs and conditioned level/pulse outputs
interface btn_debounce_if #(
  parameter int N = 5
);
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-channel synchronising button debouncer with edge pulses
module btn_debounce #(
  parameter int N       = 5,
  parameter int DEB_CNT = 1_000_000,
  parameter int CW      = $clog2(DEB_CNT)
) (
  input logic         clk,
  input logic         rst_n,
  btn_debounce_if.slave bus
);

  localparam logic [1:0] S_LOW    = 2'd0;
  localparam logic [1:0] S_WAIT_H = 2'd1;
  localparam logic [1:0] S_HIGH   = 2'd2;
  localparam logic [1:0] S_WAIT_L = 2'd3;

  // Terminal count: the WAIT state has then seen DEB_CNT+1 stable samples
  // including the one that entered it.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          sync0;
    logic          sync1;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          rise;
    logic          fall;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync0 <= 1'b0;
        sync1 <= 1'b0;
      end else begin
        sync0 <= bus.btn_in[i];
        sync1 <= sync0;
      end
    end

    // Debounce FSM; level and pulses are updated on the accepting edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_LOW;
        cnt   <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        case (state)
          S_LOW: begin
            if (sync1) begin
              state <= S_WAIT_H;
              cnt   <= '0;
            end
          end
          S_WAIT_H: begin
            if (!sync1) begin
              state <= S_LOW;
            end else if (cnt == CNT_LAST) begin
              state <= S_HIGH;
              level <= 1'b1;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HIGH: begin
            if (!sync1) begin
              state <= S_WAIT_L;
              cnt   <= '0;
            end
          end
          S_WAIT_L: begin
            if (sync1) begin
              state <= S_HIGH;
            end else if (cnt == CNT_LAST) begin
              state <= S_LOW;
              level <= 1'b0;
              fall  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= S_LOW;
        endcase
      end
    end

    assign bus.btn_level[i] = level;
    assign bus.btn_rise[i]  = rise;
    assign bus.btn_fall[i]  = fall;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button/switch debouncer clocked from the 100 MHz system clock. It conditions raw board inputs before they reach the clock-divider stage: the STEP mode switch, the divider reset button, and the CPU single-step/user buttons. Each channel synchronises its input, filters bounce with a per-channel state machine and counter, and produces a clean level plus single-cycle rise and fall pulses.

## Interface

- N, default 5: number of independent input channels (≥1).
- DEB_CNT, default 1_000_000: consecutive stable cycles required to accept a change (10 ms at 100 MHz). Minimum 2.
- CW, default $clog2(DEB_CNT): width of each channel counter. Derived; not overridden.
- clk, input, 1: 100 MHz system clock. All logic uses its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_in, input, N: raw, asynchronous, bouncing inputs. Active-high.
- btn_level, output, N: debounced level per channel.
- btn_rise, output, N: one-cycle pulse when btn_level goes 0→1.
- btn_fall, output, N: one-cycle pulse when btn_level goes 1→0.

## Operation

- All channels are identical and fully independent. Use a generate loop; no shared state between channels.
- Synchroniser: two flops per channel, sync0 ← btn_in[i] and sync1 ← sync0, both reset to 0. Only sync1 feeds the FSM.
- Per-channel FSM, 4 states, reset state S_LOW:
  - S_LOW (level 0): if sync1=1, go to S_WAIT_H and set cnt to 0.
  - S_WAIT_H (level 0): if sync1=0, go to S_LOW (abort, no pulse). Otherwise, if cnt = DEB_CNT-1, go to S_HIGH. Otherwise cnt increments.
  - S_HIGH (level 1): if sync1=0, go to S_WAIT_L and set cnt to 0.
  - S_WAIT_L (level 1): if sync1=1, go to S_HIGH (abort). Otherwise, if cnt = DEB_CNT-1, go to S_LOW. Otherwise cnt increments.
- btn_level is registered and is 1 exactly in S_HIGH and S_WAIT_L.
- btn_rise is registered. It is 1 for the single cycle after the S_WAIT_H→S_HIGH transition and 0 otherwise. btn_fall is symmetric for S_WAIT_L→S_LOW.
- The counter is CW bits and only counts in WAIT states, so it never wraps. It is cleared on every entry to a WAIT state.
- An abort does not produce a pulse and does not change btn_level.
- Reset (any time, including mid-count):
  - btn_level=0, btn_rise=0, btn_fall=0, synchronisers=0, cnt=0, state=S_LOW, all asynchronously.
- If an input is held high through reset release, it debounces normally. The channel then produces a btn_rise pulse once it reaches S_HIGH.

## Timing

- Let btn_in[i] go high before edge 0 and stay high:
  - sync1=1 after edge 1.
  - S_WAIT_H is entered at edge 2.
  - S_HIGH is entered at edge DEB_CNT+2.
- btn_level=1 and btn_rise=1 after edge DEB_CNT+2. btn_rise returns to 0 after edge DEB_CNT+3.
- Release latency is identical: btn_fall pulses after edge DEB_CNT+2 relative to the first low sample.
- A pulse or glitch on btn_in lasting fewer than DEB_CNT consecutive synchronised cycles is rejected entirely.
- Exactly one rise (or fall) pulse is produced per accepted transition. Rise and fall are never 1 in the same cycle on one channel.
- Simultaneous changes on several channels are handled independently, with identical latency per channel.

## Test plan

- Reset: drive rst_n=0 while btn_in toggles at random.
  - Required: all outputs stay 0 throughout.
  - Release rst_n with btn_in=0: outputs remain 0 for 100 cycles.
- Clean press (DEB_CNT=4): btn_in[0] goes 0→1 before edge 0 and is held.
  - Required: btn_level[0]=1 and btn_rise[0]=1 after edge 6.
  - Required: btn_rise[0]=0 after edge 7.
  - Required: other channels stay 0.
- Bounce rejection (DEB_CNT=4): btn_in[1] toggles with high periods of 3 cycles and low periods of 2 cycles, for 40 cycles, then is held high.
  - Required: no output activity during the toggling.
  - Required: exactly one btn_rise[1], 6 cycles after the final stable high begins.
- Release (DEB_CNT=4): with btn_level[2]=1, btn_in[2] drops to 0 and is held.
  - Required: btn_fall[2]=1 for one cycle and btn_level[2]=0 after edge 6.
- Mid-count reset: assert rst_n=0 while channel 3 is in S_WAIT_H with cnt=2, keeping btn_in[3]=1.
  - Required: immediate clear of all outputs.
  - Required after release: btn_rise[3] occurs DEB_CNT+2 edges later.
- Parallel channels: all N inputs rise on the same cycle.
  - Required: all btn_rise bits pulse together on the same edge.
  - Required: no cross-channel interference.
